// File: rtl/blob_centroid_pkg.sv
// Shared types and default widths for the blob centroid datapath.
// The divider width helper keeps the top and its dividers in agreement.
package blob_centroid_pkg;

  localparam int unsigned X_WIDTH_DEF    = 11;
  localparam int unsigned Y_WIDTH_DEF    = 10;
  localparam int unsigned COUNT_W_DEF    = 20;
  localparam int unsigned MIN_PIXELS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_e;

  // Both dividers run over the wider (x) sum so they finish on the same cycle.
  function automatic int unsigned div_width(input int unsigned coord_w,
                                            input int unsigned count_w);
    return coord_w + count_w;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring serial divider: one quotient bit per cycle, W cycles after start.
// done is high during the cycle whose clock edge retires the final bit.
module serial_divider #(
  parameter int unsigned W  = 31,
  parameter int unsigned DW = 20,
  parameter int unsigned QW = 11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start,
  input  logic [W-1:0]  dividend,
  input  logic [DW-1:0] divisor,
  output logic [QW-1:0] quotient,
  output logic          done
);

  localparam int unsigned CW = $clog2(W + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW:0]   trial;
  logic [DW:0]   diff;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    trial  = {rem_q, quo_q[W-1]};
    diff   = trial - {1'b0, divisor};
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(W);
      quo_d  = dividend;
      rem_d  = '0;
    end else if (busy_q) begin
      if (trial >= {1'b0, divisor}) begin
        rem_d = diff[DW-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = trial[DW-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != CW'(1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: the shift registers are pure datapath reloaded on every start, so
  // they carry no reset; only the control flops above need one.
  always_ff @(posedge clk_in) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
  end

  assign done     = busy_q && (cnt_q == CW'(1));
  assign quotient = quo_q[QW-1:0];

endmodule

// File: rtl/blob_centroid.sv
// Frame centroid of thresholded pixels: accumulate x/y sums, divide at frame end.
// Define BLOB_CENTROID_MIN_PIXELS_EN to suppress frames below MIN_PIXELS pixels.
module blob_centroid
  import blob_centroid_pkg::*;
#(
  parameter int unsigned X_WIDTH    = X_WIDTH_DEF,
  parameter int unsigned Y_WIDTH    = Y_WIDTH_DEF,
  parameter int unsigned COUNT_W    = COUNT_W_DEF,
  parameter int unsigned MIN_PIXELS = MIN_PIXELS_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [X_WIDTH-1:0] x_in,
  input  logic [Y_WIDTH-1:0] y_in,
  input  logic               valid_in,
  input  logic               tabulate_in,
  output logic [X_WIDTH-1:0] x_out,
  output logic [Y_WIDTH-1:0] y_out,
  output logic               valid_out
);

  localparam int unsigned D    = div_width(X_WIDTH, COUNT_W);
  localparam int unsigned XS_W = X_WIDTH + COUNT_W;
  localparam int unsigned YS_W = Y_WIDTH + COUNT_W;

`ifdef BLOB_CENTROID_MIN_PIXELS_EN
  localparam bit MIN_EN = 1'b1;
`else
  localparam bit MIN_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [XS_W-1:0]     x_sum_q, x_sum_d;
  logic [YS_W-1:0]     y_sum_q, y_sum_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [COUNT_W-1:0]  op_count_q, op_count_d;
  logic [X_WIDTH-1:0]  x_out_q, x_out_d;
  logic [Y_WIDTH-1:0]  y_out_q, y_out_d;
  logic                valid_out_q, valid_out_d;

  logic                accept;
  logic [XS_W-1:0]     close_x;
  logic [YS_W-1:0]     close_y;
  logic [COUNT_W-1:0]  close_count;
  logic                report;
  logic                start;
  logic [X_WIDTH-1:0]  x_quo;
  logic [Y_WIDTH-1:0]  y_quo;
  logic                x_done, y_done;

  // A saturated counter freezes the whole frame so sums stay consistent with it.
  assign accept      = valid_in && (count_q != '1);
  assign close_x     = x_sum_q + (accept ? XS_W'(x_in) : '0);
  assign close_y     = y_sum_q + (accept ? YS_W'(y_in) : '0);
  assign close_count = count_q + COUNT_W'(accept);
  assign report      = (close_count != '0) &&
                       (!MIN_EN || (close_count >= COUNT_W'(MIN_PIXELS)));
  assign start       = tabulate_in && (state_q == IDLE) && report;

  always_comb begin
    x_sum_d    = x_sum_q;
    y_sum_d    = y_sum_q;
    count_d    = count_q;
    op_count_d = op_count_q;
    if (start) op_count_d = close_count;
    if (tabulate_in) begin
      x_sum_d = '0;
      y_sum_d = '0;
      count_d = '0;
    end else if (accept) begin
      x_sum_d = close_x;
      y_sum_d = close_y;
      count_d = close_count;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    valid_out_d = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = DIVIDE;
      DIVIDE:  if (x_done && y_done) state_d = DONE;
      DONE: begin
        x_out_d     = x_quo;
        y_out_d     = y_quo;
        valid_out_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      x_sum_q     <= '0;
      y_sum_q     <= '0;
      count_q     <= '0;
      op_count_q  <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_sum_q     <= x_sum_d;
      y_sum_q     <= y_sum_d;
      count_q     <= count_d;
      op_count_q  <= op_count_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // The divisor comes from op_count_q, loaded on the same edge as start.
  serial_divider #(.W(D), .DW(COUNT_W), .QW(X_WIDTH)) u_x_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (start),
    .dividend (D'(close_x)),
    .divisor  (op_count_q),
    .quotient (x_quo),
    .done     (x_done)
  );

  serial_divider #(.W(D), .DW(COUNT_W), .QW(Y_WIDTH)) u_y_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (start),
    .dividend (D'(close_y)),
    .divisor  (op_count_q),
    .quotient (y_quo),
    .done     (y_done)
  );

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_blob_centroid.sv
// Scoreboard bench for blob_centroid: directed frames push expected centroids,
// a negedge monitor pops and checks value and arrival cycle on each valid_out.
module tb_blob_centroid;

  localparam int LAT = 33;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        valid_in;
  logic        tabulate_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;

  typedef struct {
    int x;
    int y;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  blob_centroid dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .valid_in    (valid_in),
    .tabulate_in (tabulate_in),
    .x_out       (x_out),
    .y_out       (y_out),
    .valid_out   (valid_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && valid_out) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got x=%0d y=%0d, expected no result (cycle %0d)",
                 x_out, y_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("x_out", int'(x_out), e.x);
        check("y_out", int'(y_out), e.y);
        check("latency", cyc, e.due);
      end
    end
  end

  task automatic drive(input bit v, input bit t, input int x, input int y);
    @(negedge clk_in);
    valid_in    = v;
    tabulate_in = t;
    x_in        = 11'(x);
    y_in        = 10'(y);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  // Tabulate (optionally with a same-cycle pixel) and expect a centroid.
  task automatic tab_expect(input int ex, input int ey,
                            input bit v, input int px, input int py);
    drive(v, 1, px, py);
    sb.push_back('{ex, ey, cyc + LAT});
  endtask

  initial begin
    rst_in      = 1'b1;
    valid_in    = 1'b0;
    tabulate_in = 1'b0;
    x_in        = '0;
    y_in        = '0;
    repeat (3) @(negedge clk_in);
    check("reset_x_out", int'(x_out), 0);
    check("reset_y_out", int'(y_out), 0);
    check("reset_valid_out", int'(valid_out), 0);
    rst_in = 1'b0;
    idle(2);

    // Single pixel
    drive(1, 0, 100, 50);
    tab_expect(100, 50, 0, 0, 0);
    idle(40);

    // Two pixels, the second coincident with tabulate: floor(31/2), floor(61/2)
    drive(1, 0, 10, 20);
    tab_expect(15, 30, 1, 21, 41);
    idle(40);

    // Empty frame: nothing reported, outputs hold
    drive(0, 1, 0, 0);
    idle(40);
    check("hold_x_empty", int'(x_out), 15);
    check("hold_y_empty", int'(y_out), 30);

    // Second tabulate 10 cycles after the first is dropped with its pixel
    drive(1, 0, 200, 100);
    tab_expect(200, 100, 0, 0, 0);
    idle(9);
    drive(1, 1, 400, 400);
    drive(1, 0, 50, 60);
    drive(1, 0, 70, 80);
    idle(40);
    tab_expect(60, 70, 0, 0, 0);
    idle(40);

    // Fifteen pixels: below the noise floor only when the threshold is enabled
    repeat (15) drive(1, 0, 5, 7);
`ifdef BLOB_CENTROID_MIN_PIXELS_EN
    drive(0, 1, 0, 0);
    idle(40);
    check("hold_x_min", int'(x_out), 60);
    check("hold_y_min", int'(y_out), 70);
`else
    tab_expect(5, 7, 0, 0, 0);
    idle(40);
`endif

    // Sixteen pixels at (8,8)
    repeat (16) drive(1, 0, 8, 8);
    tab_expect(8, 8, 0, 0, 0);
    idle(40);

    // Reset 10 cycles into a division aborts it and zeroes the outputs
    drive(1, 0, 33, 44);
    drive(0, 1, 0, 0);
    idle(10);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("abort_x_out", int'(x_out), 0);
    check("abort_y_out", int'(y_out), 0);
    idle(40);
    check("abort_x_hold", int'(x_out), 0);

    // Fresh frame after the abort
    drive(1, 0, 7, 9);
    drive(1, 0, 9, 11);
    tab_expect(8, 10, 0, 0, 0);
    idle(40);

    // Coordinates at the top of their ranges: floor(4093/2), floor(2045/2)
    drive(1, 0, 2047, 1023);
    tab_expect(2046, 1022, 1, 2046, 1022);
    idle(40);

    check("pending_results", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
